// File: rtl/uart_pkg.sv
// Shared constants for the UART APB front-end: register map, bit positions,
// TX sequencer states and the CTRL reset value.
package uart_pkg;
  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_IRQ_EN = 8'h0C;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_TX_ACTIVE  = 4;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int CTRL_OVR_CLR = 2;

  localparam int IE_TX_EMPTY = 0;
  localparam int IE_RX_VALID = 1;
  localparam int IE_OVERRUN  = 2;

  localparam logic [7:0] CTRL_RST = 8'h03;

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_e;
endpackage

// File: rtl/uart_apb_ctrl_if.sv
// APB slave bus bundle for the UART controller (zero-wait-state, 8-bit data).
interface uart_apb_ctrl_if;
  logic       PSEL2;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (output PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the TX sequencer. rdata shows the head entry;
// a push and a pop in the same cycle are allowed even when full.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_apb_ctrl.sv
// APB register front-end and TX/RX sequencer for the UART pair.
// Define UART_CTRL_IRQ_EN to add the IRQ_EN register (0x0C) and the irq output.
module uart_apb_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  uart_apb_ctrl_if.slave  apb,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_done,
  input  logic            rx_done,
  input  logic [7:0]      rx_data
`ifdef UART_CTRL_IRQ_EN
  ,
  output logic            irq
`endif
);
  tx_state_e  state, state_nxt;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       tx_en, rx_en, rx_valid, rx_overrun, tx_active;
  logic [7:0] rx_byte, status, rd_mux;
  logic       access, wr, rd, data_rd;
  logic       sel_data, sel_status, sel_ctrl, sel_ie, mapped;

  assign access     = apb.PSEL2 & apb.PENABLE;
  assign wr         = access & apb.PWRITE;
  assign rd         = access & ~apb.PWRITE;
  assign sel_data   = (apb.PADDR == ADDR_DATA);
  assign sel_status = (apb.PADDR == ADDR_STATUS);
  assign sel_ctrl   = (apb.PADDR == ADDR_CTRL);
  assign data_rd    = rd & sel_data;

`ifdef UART_CTRL_IRQ_EN
  logic [2:0] ie;
  assign sel_ie = (apb.PADDR == ADDR_IRQ_EN);
`else
  assign sel_ie = 1'b0;
`endif
  assign mapped = sel_data | sel_status | sel_ctrl | sel_ie;

  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign fifo_push   = wr & sel_data & (~fifo_full | fifo_pop);
  assign fifo_pop    = (state == TX_LOAD);
  assign tx_active   = (state != TX_IDLE);

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & (~mapped | (apb.PWRITE & sel_data & fifo_full & ~fifo_pop));
  assign apb.PRDATA  = rd ? rd_mux : 8'h00;

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_EMPTY]   = fifo_empty;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_TX_ACTIVE]  = tx_active;
  end

  always_comb begin
    rd_mux = '0;
    if (sel_data)        rd_mux = rx_byte;
    else if (sel_status) rd_mux = status;
    else if (sel_ctrl) begin
      rd_mux[CTRL_TX_EN] = tx_en;
      rd_mux[CTRL_RX_EN] = rx_en;
    end
`ifdef UART_CTRL_IRQ_EN
    else if (sel_ie)     rd_mux[2:0] = ie;
`endif
  end

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (apb.PWDATA),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= TX_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE: if (tx_en && !fifo_empty) state_nxt = TX_LOAD;
      TX_LOAD: state_nxt = TX_WAIT;
      TX_WAIT: if (tx_done) state_nxt = TX_IDLE;
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Head is latched on entry to LOAD so tx_data is already valid alongside tx_start.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= (state_nxt == TX_LOAD) && (state == TX_IDLE);
      if ((state_nxt == TX_LOAD) && (state == TX_IDLE)) tx_data <= fifo_rdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_en <= CTRL_RST[CTRL_TX_EN];
      rx_en <= CTRL_RST[CTRL_RX_EN];
    end else if (wr && sel_ctrl) begin
      tx_en <= apb.PWDATA[CTRL_TX_EN];
      rx_en <= apb.PWDATA[CTRL_RX_EN];
    end
  end

  // A capture coinciding with a DATA read keeps rx_valid set and is not an overrun.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_byte    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr && sel_ctrl && apb.PWDATA[CTRL_OVR_CLR]) rx_overrun <= 1'b0;
      if (rx_done && rx_en) begin
        rx_byte  <= rx_data;
        rx_valid <= 1'b1;
        if (rx_valid && !data_rd) rx_overrun <= 1'b1;
      end else if (data_rd) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_CTRL_IRQ_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ie  <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && sel_ie) ie <= apb.PWDATA[2:0];
      irq <= (fifo_empty & ie[IE_TX_EMPTY]) | (rx_valid & ie[IE_RX_VALID]) |
             (rx_overrun & ie[IE_OVERRUN]);
    end
  end
`endif

  logic unused_pwdata;
  assign unused_pwdata = &{1'b0, apb.PWDATA[7:3]};
endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Self-checking bench for uart_apb_ctrl: queue/timestamp reference model plus
// a per-cycle compare process and directed register-level scenarios.
module tb_uart_apb_ctrl;
  import uart_pkg::*;
  localparam int DEPTH = 4;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
`ifdef UART_CTRL_IRQ_EN
  logic       irq;
`endif

  uart_apb_ctrl_if apb();

  uart_apb_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .apb      (apb.slave),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .rx_done  (rx_done),
    .rx_data  (rx_data)
`ifdef UART_CTRL_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 PCLK = ~PCLK;

  int ncyc = 0;
  always @(posedge PCLK) ncyc <= ncyc + 1;

  int n_chk = 0, n_err = 0;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  bit         busy = 0;
  int         cyc = 0, start_cyc = -10;
  logic [7:0] m_txd = 8'h00, m_rxb = 8'h00;
  bit         m_tx_en = 1, m_rx_en = 1, m_rxv = 0, m_ovr = 0;
  logic [2:0] m_ie = 3'b0;
  bit         m_irq = 0;
  bit         s_acc, s_wr, s_rd, popping, starting, done_now, push_ok, rx_en_pre;

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    case (a)
      ADDR_DATA:   return m_rxb;
      ADDR_STATUS: return {3'b000, busy, m_ovr, m_rxv, q.size() == 0, q.size() == DEPTH};
      ADDR_CTRL:   return {6'b0, m_rx_en, m_tx_en};
`ifdef UART_CTRL_IRQ_EN
      ADDR_IRQ_EN: return {5'b0, m_ie};
`endif
      default:     return 8'h00;
    endcase
  endfunction

  function automatic bit exp_err(input logic [7:0] a, input bit w);
    bit mapped;
    mapped = (a == ADDR_DATA) || (a == ADDR_STATUS) || (a == ADDR_CTRL);
`ifdef UART_CTRL_IRQ_EN
    mapped = mapped || (a == ADDR_IRQ_EN);
`endif
    return !mapped || (w && a == ADDR_DATA && q.size() == DEPTH && !(busy && start_cyc == cyc));
  endfunction

  // cycle N of the model = the clock period following edge N
  initial forever begin
    @(posedge PCLK or negedge PRESETn);
    if (!PRESETn) begin
      q.delete(); busy = 0; start_cyc = -10; m_txd = 8'h00;
      m_tx_en = 1; m_rx_en = 1; m_rxv = 0; m_ovr = 0; m_rxb = 8'h00; m_ie = 3'b0; m_irq = 0;
    end else begin
      cyc++;
      s_acc    = apb.PSEL2 && apb.PENABLE;
      s_wr     = s_acc && apb.PWRITE;
      s_rd     = s_acc && !apb.PWRITE;
      popping  = busy && (start_cyc == cyc - 1);
      done_now = busy && tx_done && (cyc - 1 > start_cyc);
      starting = !busy && m_tx_en && (q.size() != 0);
      push_ok  = s_wr && apb.PADDR == ADDR_DATA && (q.size() < DEPTH || popping);
      m_irq    = (q.size() == 0 && m_ie[0]) || (m_rxv && m_ie[1]) || (m_ovr && m_ie[2]);
      if (starting) begin busy = 1; start_cyc = cyc; m_txd = q[0]; end
      if (done_now) busy = 0;
      if (popping) void'(q.pop_front());
      if (push_ok) q.push_back(apb.PWDATA);
      rx_en_pre = m_rx_en;
      if (s_wr && apb.PADDR == ADDR_CTRL) begin
        m_tx_en = apb.PWDATA[0];
        m_rx_en = apb.PWDATA[1];
        if (apb.PWDATA[2]) m_ovr = 0;
      end
`ifdef UART_CTRL_IRQ_EN
      if (s_wr && apb.PADDR == ADDR_IRQ_EN) m_ie = apb.PWDATA[2:0];
`endif
      if (rx_done && rx_en_pre) begin
        if (m_rxv && !(s_rd && apb.PADDR == ADDR_DATA)) m_ovr = 1;
        m_rxb = rx_data;
        m_rxv = 1;
      end else if (s_rd && apb.PADDR == ADDR_DATA) begin
        m_rxv = 0;
      end
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge PCLK);
    chk("tx_start", tx_start, busy && start_cyc == cyc);
    chk("tx_data", tx_data, m_txd);
    chk("pready", apb.PREADY, 1);
    if (apb.PSEL2 && apb.PENABLE) begin
      chk("prdata", apb.PRDATA, apb.PWRITE ? 8'h00 : exp_rd(apb.PADDR));
      chk("pslverr", apb.PSLVERR, exp_err(apb.PADDR, apb.PWRITE));
    end else begin
      chk("prdata_idle", apb.PRDATA, 0);
      chk("pslverr_idle", apb.PSLVERR, 0);
    end
`ifdef UART_CTRL_IRQ_EN
    chk("irq", irq, m_irq);
`endif
  end

  // ---------------- transmitter stand-in ----------------
  bit auto_done = 0;
  int dly = 0;
  int starts[$], dones[$];
  logic [7:0] bytes[$];

  initial forever begin
    @(posedge PCLK); #1;
    tx_done = 1'b0;
    if (!PRESETn) dly = 0;
    else if (tx_start) begin
      starts.push_back(ncyc);
      bytes.push_back(tx_data);
      if (auto_done) dly = 4;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin tx_done = 1'b1; dones.push_back(ncyc); end
    end
  end

  // ---------------- bus tasks ----------------
  int last_edge;
  task automatic apb_xfer(input bit w, input logic [7:0] a, input logic [7:0] wd,
                          input bit inj, input logic [7:0] rb,
                          output logic [7:0] rdv, output logic errv);
    @(posedge PCLK); #1;
    apb.PSEL2 = 1; apb.PENABLE = 0; apb.PWRITE = w; apb.PADDR = a; apb.PWDATA = wd;
    @(posedge PCLK); #1;
    apb.PENABLE = 1;
    if (inj) begin rx_done = 1; rx_data = rb; end
    @(negedge PCLK);
    rdv = apb.PRDATA; errv = apb.PSLVERR;
    @(posedge PCLK); #1;
    last_edge = ncyc;
    apb.PSEL2 = 0; apb.PENABLE = 0; rx_done = 0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d, input bit e, input string nm);
    logic [7:0] rdv; logic errv;
    apb_xfer(1, a, d, 0, 8'h00, rdv, errv);
    chk(nm, errv, e);
  endtask

  task automatic rd_reg(input logic [7:0] a, input logic [7:0] e, input string nm);
    logic [7:0] rdv; logic errv;
    apb_xfer(0, a, 8'h00, 0, 8'h00, rdv, errv);
    chk(nm, rdv, e);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(posedge PCLK); #1; rx_done = 1; rx_data = b;
    @(posedge PCLK); #1; rx_done = 0;
  endtask

  task automatic wait_cnt(input bit use_starts, input int n, input string nm);
    int k = 0;
    while (((use_starts ? starts.size() : dones.size()) < n) && k < 300) begin
      @(posedge PCLK); k++;
    end
    chk(nm, (use_starts ? starts.size() : dones.size()) >= n, 1);
  endtask

  logic [7:0] vec [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int pe, n0;
    logic [7:0] rdv; logic errv;
    apb.PSEL2 = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 0; apb.PWDATA = 0;
    repeat (3) @(posedge PCLK); #1 PRESETn = 1;

    // reset state
    rd_reg(ADDR_STATUS, 8'h02, "rst_status");
    rd_reg(ADDR_CTRL,   8'h03, "rst_ctrl");
    chk("rst_tx_start", tx_start, 0);

    // single frame and push-to-start latency
    auto_done = 1;
    wr_reg(ADDR_DATA, 8'hA5, 0, "push_a5");
    pe = last_edge;
    rd_reg(ADDR_STATUS, 8'h12, "status_active");
    wait_cnt(0, 1, "done_a5_timeout");
    chk("start_latency", starts[0] - pe, 1);
    chk("tx_byte_a5", bytes[0], 8'hA5);
    repeat (2) @(posedge PCLK);
    rd_reg(ADDR_STATUS, 8'h02, "status_idle");

    // fill with tx disabled, overflow, then drain in order
    starts.delete(); dones.delete(); bytes.delete();
    wr_reg(ADDR_CTRL, 8'h02, 0, "tx_dis");
    for (int i = 0; i < 4; i++) wr_reg(ADDR_DATA, vec[i], 0, "fill_push");
    wr_reg(ADDR_DATA, 8'h55, 1, "overflow_err");
    rd_reg(ADDR_STATUS, 8'h01, "status_full");
    wr_reg(ADDR_CTRL, 8'h03, 0, "tx_en");
    wait_cnt(0, 4, "drain_timeout");
    for (int i = 0; i < 4; i++) chk("drain_order", bytes[i], vec[i]);
    for (int i = 1; i < 4; i++) chk("b2b_gap", starts[i] - dones[i-1], 2);
    rd_reg(ADDR_STATUS, 8'h02, "status_drained");

    // RX capture, read clear, overrun and clear
    rx_pulse(8'h3C);
    rd_reg(ADDR_STATUS, 8'h06, "rx_valid");
    rd_reg(ADDR_DATA,   8'h3C, "rx_byte");
    rd_reg(ADDR_STATUS, 8'h02, "rx_cleared");
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    rd_reg(ADDR_STATUS, 8'h0E, "rx_overrun");
    wr_reg(ADDR_CTRL, 8'h07, 0, "ovr_clr");
    rd_reg(ADDR_STATUS, 8'h06, "ovr_cleared");
    rd_reg(ADDR_CTRL,   8'h03, "ctrl_b2_reads0");
    rd_reg(ADDR_DATA,   8'h22, "rx_overwritten");
    // read racing a new byte: old byte returned, new byte held, no overrun
    rx_pulse(8'h44);
    apb_xfer(0, ADDR_DATA, 8'h00, 1, 8'h55, rdv, errv);
    chk("race_old_byte", rdv, 8'h44);
    rd_reg(ADDR_STATUS, 8'h06, "race_status");
    rd_reg(ADDR_DATA,   8'h55, "race_new_byte");

    // unmapped addresses
    apb_xfer(0, 8'h10, 8'h00, 0, 8'h00, rdv, errv);
    chk("unmapped_rd_data", rdv, 8'h00);
    chk("unmapped_rd_err", errv, 1);
    wr_reg(8'h10, 8'h00, 1, "unmapped_wr_err");
    rd_reg(ADDR_CTRL,   8'h03, "unmapped_ctrl_kept");
    rd_reg(ADDR_STATUS, 8'h02, "unmapped_status_kept");
`ifdef UART_CTRL_IRQ_EN
    wr_reg(ADDR_IRQ_EN, 8'h00, 0, "irq_en_mapped");
`else
    wr_reg(ADDR_IRQ_EN, 8'h00, 1, "irq_en_unmapped");
`endif

    // reset in WAIT with two bytes still queued
    auto_done = 0;
    starts.delete();
    wr_reg(ADDR_CTRL, 8'h02, 0, "tx_dis2");
    for (int i = 0; i < 3; i++) wr_reg(ADDR_DATA, vec[i], 0, "q_push");
    wr_reg(ADDR_CTRL, 8'h03, 0, "tx_en2");
    wait_cnt(1, 1, "start_before_rst");
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1;
    chk("rst_mid_tx_start", tx_start, 0);
    rd_reg(ADDR_STATUS, 8'h02, "rst_mid_status");
    n0 = starts.size();
    repeat (10) @(posedge PCLK);
    chk("no_start_after_rst", starts.size(), n0);
    rd_reg(ADDR_CTRL, 8'h03, "rst_mid_ctrl");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end
endmodule
